// File: rtl/time_ascii_tx.sv
// Snapshots the stopwatch time on a request and streams it as ASCII "HH:MM:SS.cc" (optionally
// followed by CR LF) over a valid/ready byte interface, with an optional periodic auto-report.
module time_ascii_tx #(
    parameter int SEND_CRLF   = 1,
    parameter int AUTO_PERIOD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [6:0] milliseconds,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       dropped
);

    localparam logic [3:0] LAST_IDX = (SEND_CRLF != 0) ? 4'd12 : 4'd10;

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state;
    logic [3:0] idx;
    logic [5:0] snap_h;
    logic [5:0] snap_m;
    logic [5:0] snap_s;
    logic [6:0] snap_c;
    logic       auto_tick;
    logic       req;

    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    function automatic logic [7:0] tens_char(input logic [6:0] v);
        logic [6:0] s;
        s = sat99(v);
        return 8'h30 + {1'b0, s / 7'd10};
    endfunction

    function automatic logic [7:0] ones_char(input logic [6:0] v);
        logic [6:0] s;
        s = sat99(v);
        return 8'h30 + {1'b0, s % 7'd10};
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [6:0] h,
                                              input logic [6:0] m, input logic [6:0] s,
                                              input logic [6:0] c);
        case (i)
            4'd0:    return tens_char(h);
            4'd1:    return ones_char(h);
            4'd2:    return 8'h3A;
            4'd3:    return tens_char(m);
            4'd4:    return ones_char(m);
            4'd5:    return 8'h3A;
            4'd6:    return tens_char(s);
            4'd7:    return ones_char(s);
            4'd8:    return 8'h2E;
            4'd9:    return tens_char(c);
            4'd10:   return ones_char(c);
            4'd11:   return 8'h0D;
            4'd12:   return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    generate
        if (AUTO_PERIOD >= 2) begin : g_auto
            localparam int CW = $clog2(AUTO_PERIOD);
            localparam logic [CW-1:0] LAST_CNT = CW'(AUTO_PERIOD - 1);
            logic [CW-1:0] period_cnt;

            // Free-running regardless of FSM state so reports stay on a fixed cadence
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    period_cnt <= '0;
                else if (period_cnt == LAST_CNT)
                    period_cnt <= '0;
                else
                    period_cnt <= period_cnt + CW'(1);
            end

            assign auto_tick = (period_cnt == LAST_CNT);
        end else begin : g_no_auto
            assign auto_tick = 1'b0;
        end
    endgenerate

    assign req = trigger | auto_tick;

    // The first byte is built from the live inputs because the snapshot loads on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 4'd0;
            snap_h   <= '0;
            snap_m   <= '0;
            snap_s   <= '0;
            snap_c   <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        snap_h   <= hours;
                        snap_m   <= minutes;
                        snap_s   <= seconds;
                        snap_c   <= milliseconds;
                        idx      <= 4'd0;
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        tx_data  <= frame_byte(4'd0, {1'b0, hours}, {1'b0, minutes},
                                               {1'b0, seconds}, milliseconds);
                    end
                end
                SEND: begin
                    dropped <= req;
                    if (tx_ready) begin
                        if (idx == LAST_IDX) begin
                            state    <= IDLE;
                            idx      <= 4'd0;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            tx_data  <= 8'h00;
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= frame_byte(idx + 4'd1, {1'b0, snap_h}, {1'b0, snap_m},
                                                  {1'b0, snap_s}, snap_c);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_ascii_tx.sv
// Self-checking bench for time_ascii_tx: three instances (default, no CR/LF, auto period 100)
// with a per-instance expected-byte scoreboard checked on every handshake.
module tb_time_ascii_tx;

    logic       clk;
    logic       reset;
    logic       reset_auto;
    logic       trigger;
    logic       trigger_nc;
    logic       trig_auto;
    logic       rdy_m;
    logic       rdy_nc;
    logic       rdy_auto;
    logic [5:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] ms;

    logic [7:0] data_m, data_nc, data_a;
    logic       valid_m, valid_nc, valid_a;
    logic       busy_m, busy_nc, busy_a;
    logic       drop_m, drop_nc, drop_a;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q [3][$];
    logic [7:0] mon_data [3];
    logic       mon_valid [3];
    logic       mon_ready [3];
    logic       mon_drop [3];
    logic       mon_rst [3];
    string      dut_name [3] = '{"main", "nocrlf", "auto"};
    int         drop_cnt [3] = '{0, 0, 0};
    int         start_cnt [3] = '{0, 0, 0};
    int         last_drop_cyc [3] = '{0, 0, 0};
    bit         prev_valid [3] = '{0, 0, 0};
    bit         stall [3] = '{0, 0, 0};
    logic [7:0] stall_data [3];
    int         auto_starts [$];

    time_ascii_tx #(.SEND_CRLF(1), .AUTO_PERIOD(0)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .hours(hours), .minutes(minutes),
        .seconds(seconds), .milliseconds(ms), .tx_data(data_m), .tx_valid(valid_m),
        .tx_ready(rdy_m), .busy(busy_m), .dropped(drop_m)
    );

    time_ascii_tx #(.SEND_CRLF(0), .AUTO_PERIOD(0)) dut_nc (
        .clk(clk), .reset(reset), .trigger(trigger_nc), .hours(hours), .minutes(minutes),
        .seconds(seconds), .milliseconds(ms), .tx_data(data_nc), .tx_valid(valid_nc),
        .tx_ready(rdy_nc), .busy(busy_nc), .dropped(drop_nc)
    );

    time_ascii_tx #(.SEND_CRLF(1), .AUTO_PERIOD(100)) dut_auto (
        .clk(clk), .reset(reset_auto), .trigger(trig_auto), .hours(hours), .minutes(minutes),
        .seconds(seconds), .milliseconds(ms), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(rdy_auto), .busy(busy_a), .dropped(drop_a)
    );

    assign mon_data[0] = data_m;   assign mon_data[1] = data_nc;   assign mon_data[2] = data_a;
    assign mon_valid[0] = valid_m; assign mon_valid[1] = valid_nc; assign mon_valid[2] = valid_a;
    assign mon_ready[0] = rdy_m;   assign mon_ready[1] = rdy_nc;   assign mon_ready[2] = rdy_auto;
    assign mon_drop[0] = drop_m;   assign mon_drop[1] = drop_nc;   assign mon_drop[2] = drop_a;
    assign mon_rst[0] = reset;     assign mon_rst[1] = reset;      assign mon_rst[2] = reset_auto;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                                  input logic [6:0] c);
        hours = h; minutes = m; seconds = s; ms = c;
    endtask

    task automatic push_str(input int d, input string s, input bit crlf);
        for (int i = 0; i < s.len(); i++) exp_q[d].push_back(s[i]);
        if (crlf) begin
            exp_q[d].push_back(8'h0D);
            exp_q[d].push_back(8'h0A);
        end
    endtask

    task automatic fire();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_main_done(input bit rnd, output int n);
        n = 0;
        forever begin
            if (rnd) rdy_m = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (exp_q[0].size() == 0) begin
                check_output("main_idle_after_last", {22'd0, busy_m, valid_m, data_m}, 32'd0);
                break;
            end
            if (n > 300) begin
                check_output("main_timeout", exp_q[0].size(), 0);
                break;
            end
        end
        rdy_m = 1'b1;
    endtask

    // Scoreboard: compare every accepted byte, and hold checks across stalls
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!mon_rst[d]) begin
                prev_valid[d] = 1'b0;
                stall[d] = 1'b0;
            end else begin
                if (stall[d])
                    check_output({dut_name[d], "_hold"}, {23'd0, mon_valid[d], mon_data[d]},
                                 {23'd0, 1'b1, stall_data[d]});
                if (mon_valid[d] && mon_ready[d]) begin
                    if (exp_q[d].size() == 0)
                        check_output({dut_name[d], "_extra_byte"}, exp_q[d].size(), 1);
                    else
                        check_output({dut_name[d], "_byte"}, {24'd0, mon_data[d]},
                                     {24'd0, exp_q[d].pop_front()});
                end
                stall[d] = mon_valid[d] && !mon_ready[d];
                stall_data[d] = mon_data[d];
                if (mon_drop[d]) begin
                    drop_cnt[d]++;
                    last_drop_cyc[d] = cyc;
                end
                if (mon_valid[d] && !prev_valid[d]) begin
                    start_cnt[d]++;
                    if (d == 2) auto_starts.push_back(cyc);
                end
                prev_valid[d] = mon_valid[d];
            end
        end
    end

    initial begin
        int n;
        int d0;
        int s0;
        int n0;
        int exp_off [3] = '{100, 200, 400};

        $display("[TB] time_ascii_tx bench starting");
        reset = 1'b0; reset_auto = 1'b0;
        trigger = 1'b0; trigger_nc = 1'b0; trig_auto = 1'b0;
        rdy_m = 1'b1; rdy_nc = 1'b1; rdy_auto = 1'b1;
        apply_stimulus(12, 34, 56, 78);
        tick(); tick();
        check_output("reset_main", {21'd0, valid_m, busy_m, drop_m, data_m}, 32'd0);
        check_output("reset_nocrlf", {21'd0, valid_nc, busy_nc, drop_nc, data_nc}, 32'd0);
        check_output("reset_auto", {21'd0, valid_a, busy_a, drop_a, data_a}, 32'd0);
        reset = 1'b1;
        tick();
        check_output("idle_main", {30'd0, valid_m, busy_m}, 32'd0);

        // Test 1: plain frame, ready always high
        push_str(0, "12:34:56.78", 1);
        fire();
        check_output("t1_first_byte", {22'd0, valid_m, busy_m, data_m}, {22'd0, 2'b11, 8'h31});
        wait_main_done(0, n);
        check_output("t1_frame_cycles", n, 13);
        check_output("t1_no_drop", drop_cnt[0], 0);

        // Test 2: pseudo-random back-pressure
        push_str(0, "12:34:56.78", 1);
        fire();
        wait_main_done(1, n);
        check_output("t2_frames", start_cnt[0], 2);

        // Test 3: request mid-frame plus input change
        d0 = drop_cnt[0];
        s0 = start_cnt[0];
        push_str(0, "12:34:56.78", 1);
        fire();
        repeat (4) tick();
        check_output("t3_byte4", {24'd0, data_m}, 32'h34);
        apply_stimulus(0, 0, 0, 0);
        fire();
        wait_main_done(0, n);
        repeat (5) tick();
        check_output("t3_drop_once", drop_cnt[0] - d0, 1);
        check_output("t3_one_frame", start_cnt[0] - s0, 1);
        check_output("t3_idle", {31'd0, busy_m}, 32'd0);
        apply_stimulus(12, 34, 56, 78);

        // Test 3b: request on the completing edge is dropped, not started
        push_str(0, "12:34:56.78", 1);
        fire();
        repeat (12) tick();
        check_output("t3b_last_byte", {24'd0, data_m}, 32'h0A);
        fire();
        check_output("t3b_idle", {22'd0, busy_m, valid_m, data_m}, 32'd0);
        check_output("t3b_queue", exp_q[0].size(), 0);
        repeat (5) tick();
        check_output("t3b_drops", drop_cnt[0] - d0, 2);
        check_output("t3b_no_frame", start_cnt[0] - s0, 2);

        // Test 4: saturation, with and without CR LF
        apply_stimulus(23, 59, 59, 120);
        push_str(0, "23:59:59.99", 1);
        push_str(1, "23:59:59.99", 0);
        trigger = 1'b1; trigger_nc = 1'b1;
        tick();
        trigger = 1'b0; trigger_nc = 1'b0;
        repeat (10) tick();
        check_output("t4_nc_busy", {31'd0, busy_nc}, 32'd1);
        tick();
        check_output("t4_nc_done", {30'd0, busy_nc, valid_nc}, 32'd0);
        check_output("t4_nc_queue", exp_q[1].size(), 0);
        wait_main_done(0, n);
        check_output("t4_main_tail", n, 2);
        apply_stimulus(12, 34, 56, 78);

        // Test 5: reset aborts a frame mid-stream
        push_str(0, "12:34:56.78", 1);
        fire();
        repeat (6) tick();
        check_output("t5_byte6", {24'd0, data_m}, 32'h35);
        reset = 1'b0;
        #1;
        check_output("t5_async_reset", {21'd0, valid_m, busy_m, drop_m, data_m}, 32'd0);
        exp_q[0].delete();
        tick(); tick();
        reset = 1'b1;
        tick();
        push_str(0, "12:34:56.78", 1);
        fire();
        check_output("t5_restart_byte0", {22'd0, valid_m, busy_m, data_m}, {22'd0, 2'b11, 8'h31});
        wait_main_done(0, n);
        check_output("t5_frame_cycles", n, 13);

        // Test 6: auto reports every 100 cycles, one dropped while stalled
        for (int i = 0; i < 3; i++) push_str(2, "12:34:56.78", 1);
        reset_auto = 1'b1;
        n0 = cyc;
        repeat (199) tick();
        rdy_auto = 1'b0;
        repeat (116) tick();
        rdy_auto = 1'b1;
        repeat (100) tick();
        for (int i = 0; i < 3; i++)
            check_output($sformatf("t6_start%0d", i),
                         (i < auto_starts.size()) ? auto_starts[i] : -1, n0 + exp_off[i]);
        check_output("t6_drop_count", drop_cnt[2], 1);
        check_output("t6_drop_cycle", last_drop_cyc[2], n0 + 300);
        check_output("t6_queue", exp_q[2].size(), 0);
        check_output("t6_idle", {31'd0, busy_a}, 32'd0);
        check_output("final_main_queue", exp_q[0].size(), 0);
        check_output("final_nc_drops", drop_cnt[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
